// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI-Lite subordinate register file:
//   RESP_OKAY / RESP_SLVERR  - B/R response codes
//   sub_wr_state_t           - write-channel FSM states
//   sub_rd_state_t           - read-channel FSM states
//   sub_dbg_t                - FSM state and holding flags for debug visibility
//   strb_merge()             - byte-lane merge of a new word into an old word
// ---------------------------------------------------------------------------
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} sub_wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} sub_rd_state_t;

  typedef struct packed {
    sub_wr_state_t wr_state;
    sub_rd_state_t rd_state;
    logic          aw_held;
    logic          w_held;
  } sub_dbg_t;

  // Operates on the widest supported word (64 bits / 8 lanes); narrower
  // callers zero-extend their operands and keep the low bits of the result.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_word,
                                             input logic [63:0] new_word,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = strb[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// ---------------------------------------------------------------------------
// AXI_LITE
// AXI-Lite bus bundle (AW/W/B/AR/R channels) with Master and Slave modports.
// Parameters: AXI_ADDR_WIDTH (byte address width), AXI_DATA_WIDTH (32/64).
// ---------------------------------------------------------------------------
interface AXI_LITE #(
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int AXI_DATA_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]                  aw_prot;
  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_valid;
  logic                        w_ready;
  logic [1:0]                  b_resp;
  logic                        b_valid;
  logic                        b_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]                  ar_prot;
  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_prot, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_prot, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile
// NUM_REGS x DW register storage with one strobed write port and one
// combinational read port.
//   clk_i, rst_i  clock, asynchronous active-high reset (regs -> RESET_VAL)
//   we, idx       write enable and target register index
//   wdata, wstrb  write data and per-byte lane enables
//   rd_idx        read index; rd_data returns regs[rd_idx] (current contents)
//   regs_o        flattened register contents, register i at [i*DW +: DW]
//   wr_pulse_o    one-hot strobe, high for the cycle after a write edge
// ---------------------------------------------------------------------------
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int            DW        = 32,
  parameter int            NUM_REGS  = 8,
  parameter int            IDX_W     = $clog2(NUM_REGS),
  parameter logic [DW-1:0] RESET_VAL = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  logic [DW-1:0]          wdata,
  input  logic [DW/8-1:0]        wstrb,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [DW-1:0]          rd_data,
  output logic [NUM_REGS*DW-1:0] regs_o,
  output logic [NUM_REGS-1:0]    wr_pulse_o
);

  logic [DW-1:0] regs_q [NUM_REGS];
  logic [63:0]   merged_wide;
  logic [DW-1:0] merged;
  logic          unused_merge_hi;

  always_comb begin
    merged_wide = strb_merge(64'(regs_q[idx]), 64'(wdata), 8'(wstrb));
    merged      = merged_wide[DW-1:0];
  end
  // Upper lanes of the 64-bit merge are don't-care when DW is 32.
  assign unused_merge_hi = ^merged_wide;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (we) begin
        regs_q[idx]     <= merged;
        wr_pulse_o[idx] <= 1'b1;
      end
    end
  end

  assign rd_data = regs_q[rd_idx];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DW +: DW] = regs_q[g];
  end

endmodule

// File: rtl/axi_lite_sub_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_sub_regs
// AXI-Lite subordinate mapping single-beat reads/writes onto NUM_REGS word
// registers. Write and read channels are independent, one transaction each.
//   clk_i       clock
//   rst_i       asynchronous active-high reset; aborts transactions silently
//   pp_if       AXI_LITE.Slave (aw_prot / ar_prot ignored)
//   regs_o      register contents, register i at [i*DW +: DW]
//   wr_pulse_o  one-cycle strobe per register write
//   dbg_o       FSM states and AW/W holding flags
//
// Handshakes: a transfer happens on a rising edge where valid && ready. Valid
// sources hold payload stable until that edge; ready never depends on valid.
// Out-of-range addresses (any bit above the register index set) answer
// SLVERR; reads of them return zero.
// ---------------------------------------------------------------------------
module axi_lite_sub_regs
  import axi_lite_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 16,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        NUM_REGS       = 8,
  parameter logic [AXI_DATA_WIDTH-1:0] RESET_VAL      = '0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  AXI_LITE.Slave                             pp_if,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]                wr_pulse_o,
  output sub_dbg_t                           dbg_o
);

  localparam int AW       = AXI_ADDR_WIDTH;
  localparam int DW       = AXI_DATA_WIDTH;
  localparam int BYTE_LSB = $clog2(DW / 8);
  localparam int IDX_W    = $clog2(NUM_REGS);

  function automatic logic in_range(input logic [AW-1:0] a);
    return (a >> (BYTE_LSB + IDX_W)) == '0;
  endfunction

  // ---------------- write channel ----------------
  sub_wr_state_t   wr_state, wr_next;
  logic            aw_held, w_held;
  logic [AW-1:0]   aw_addr_q;
  logic [DW-1:0]   w_data_q;
  logic [DW/8-1:0] w_strb_q;
  logic            b_valid_q;
  logic [1:0]      b_resp_q;
  logic            aw_ready, w_ready, reg_we, wr_in_range;

  assign wr_in_range = in_range(aw_addr_q);

  always_comb begin
    wr_next  = wr_state;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    reg_we   = 1'b0;
    case (wr_state)
      W_IDLE: begin
        aw_ready = ~aw_held & ~rst_i;
        w_ready  = ~w_held & ~rst_i;
        // Same-cycle handshakes count as held for the transition.
        if ((aw_held | (pp_if.aw_valid & aw_ready)) &&
            (w_held  | (pp_if.w_valid  & w_ready)))
          wr_next = W_EXEC;
      end
      W_EXEC: begin
        reg_we  = wr_in_range;
        wr_next = W_RESP;
      end
      W_RESP: if (pp_if.b_ready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state  <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      wr_state <= wr_next;
      case (wr_state)
        W_IDLE: begin
          if (pp_if.aw_valid && aw_ready) begin
            aw_addr_q <= pp_if.aw_addr;
            aw_held   <= 1'b1;
          end
          if (pp_if.w_valid && w_ready) begin
            w_data_q <= pp_if.w_data;
            w_strb_q <= pp_if.w_strb;
            w_held   <= 1'b1;
          end
        end
        W_EXEC: begin
          b_valid_q <= 1'b1;
          b_resp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end
        W_RESP: begin
          if (pp_if.b_ready) begin
            b_valid_q <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- read channel ----------------
  sub_rd_state_t rd_state, rd_next;
  logic          ar_ready;
  logic          r_valid_q;
  logic [1:0]    r_resp_q;
  logic [DW-1:0] r_data_q;
  logic [DW-1:0] rd_data;

  always_comb begin
    rd_next  = rd_state;
    ar_ready = 1'b0;
    case (rd_state)
      R_IDLE: begin
        ar_ready = ~rst_i;
        if (pp_if.ar_valid) rd_next = R_RESP;
      end
      R_RESP: if (pp_if.r_ready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // rd_data reflects register contents before any write committing on the
  // same edge, so a colliding read returns the old value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state  <= R_IDLE;
      r_valid_q <= 1'b0;
      r_resp_q  <= RESP_OKAY;
      r_data_q  <= '0;
    end else begin
      rd_state <= rd_next;
      case (rd_state)
        R_IDLE: begin
          if (pp_if.ar_valid) begin
            r_data_q  <= in_range(pp_if.ar_addr) ? rd_data : '0;
            r_resp_q  <= in_range(pp_if.ar_addr) ? RESP_OKAY : RESP_SLVERR;
            r_valid_q <= 1'b1;
          end
        end
        R_RESP: if (pp_if.r_ready) r_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // ---------------- storage ----------------
  axi_lite_regfile #(
    .DW        (DW),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .we         (reg_we),
    .idx        (aw_addr_q[BYTE_LSB +: IDX_W]),
    .wdata      (w_data_q),
    .wstrb      (w_strb_q),
    .rd_idx     (pp_if.ar_addr[BYTE_LSB +: IDX_W]),
    .rd_data    (rd_data),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

  // ---------------- bus outputs ----------------
  assign pp_if.aw_ready = aw_ready;
  assign pp_if.w_ready  = w_ready;
  assign pp_if.b_valid  = b_valid_q;
  assign pp_if.b_resp   = b_resp_q;
  assign pp_if.ar_ready = ar_ready;
  assign pp_if.r_valid  = r_valid_q;
  assign pp_if.r_resp   = r_resp_q;
  assign pp_if.r_data   = r_data_q;

  always_comb begin
    dbg_o          = '0;
    dbg_o.wr_state = wr_state;
    dbg_o.rd_state = rd_state;
    dbg_o.aw_held  = aw_held;
    dbg_o.w_held   = w_held;
  end

  // Protection attributes carry no meaning for this register file.
  logic unused_prot;
  assign unused_prot = ^{pp_if.aw_prot, pp_if.ar_prot};

endmodule

// File: tb/tb_axi_lite_sub_regs.sv
module tb_axi_lite_sub_regs;
  import axi_lite_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NR = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  AXI_LITE #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

  logic [NR*DW-1:0] regs;
  logic [NR-1:0]    pulse;
  sub_dbg_t         dbg;

  axi_lite_sub_regs #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .NUM_REGS       (NR),
    .RESET_VAL      ('0)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pp_if      (bus),
    .regs_o     (regs),
    .wr_pulse_o (pulse),
    .dbg_o      (dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int pulse_cycles = 0;
  logic [DW-1:0] exp_q[$];

  always @(negedge clk) if (|pulse) pulse_cycles++;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_at(input int i);
    return regs[i*DW +: DW];
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_aw_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    logic af, wf;
    int n;
    bus.aw_addr = a; bus.aw_valid = 1'b1;
    bus.w_data  = d; bus.w_strb   = s; bus.w_valid = 1'b1;
    n = 0;
    while ((bus.aw_valid || bus.w_valid) && n < 50) begin
      af = bus.aw_valid && bus.aw_ready;
      wf = bus.w_valid && bus.w_ready;
      @(negedge clk); n++;
      if (af) bus.aw_valid = 1'b0;
      if (wf) bus.w_valid  = 1'b0;
    end
    check("aw_w_accepted", {bus.aw_valid, bus.w_valid}, 2'b00);
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
  endtask

  task automatic wait_b(input string tag, output logic [1:0] resp);
    int n;
    n = 0;
    while (!bus.b_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_b_seen"}, bus.b_valid, 1'b1);
    resp = bus.b_resp;
    bus.b_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
    send_aw_w(a, d, s);
    wait_b(tag, resp);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a,
                         output logic [DW-1:0] data, output logic [1:0] resp);
    logic fire;
    int n;
    bus.ar_addr = a; bus.ar_valid = 1'b1;
    n = 0;
    while (bus.ar_valid && n < 50) begin
      fire = bus.ar_ready;
      @(negedge clk); n++;
      if (fire) bus.ar_valid = 1'b0;
    end
    n = 0;
    while (!bus.r_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_r_seen"}, bus.r_valid, 1'b1);
    data = bus.r_data;
    resp = bus.r_resp;
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
    bus.ar_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0]       resp;
    logic [DW-1:0]    rdata;
    logic [NR*DW-1:0] snap;
    int               p0, bcnt;

    bus.aw_addr = '0; bus.aw_prot = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_valid = 1'b0; bus.b_ready = 1'b0;
    bus.ar_addr = '0; bus.ar_prot = '0; bus.ar_valid = 1'b0; bus.r_ready = 1'b0;

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    check("rst_aw_ready", bus.aw_ready, 1'b0);
    check("rst_w_ready", bus.w_ready, 1'b0);
    check("rst_ar_ready", bus.ar_ready, 1'b0);
    check("rst_b_valid", bus.b_valid, 1'b0);
    check("rst_r_valid", bus.r_valid, 1'b0);
    check("rst_r_data", bus.r_data, 32'h0);
    check("rst_regs", regs, '0);
    check("rst_pulse", pulse, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("idle_aw_ready", bus.aw_ready, 1'b1);
    check("idle_ar_ready", bus.ar_ready, 1'b1);
    check("idle_wr_state", dbg.wr_state, W_IDLE);

    // 1: AW and W together, b_ready high.
    bus.aw_addr = 16'h0004; bus.aw_valid = 1'b1;
    bus.w_data = 32'hDEADBEEF; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    bus.b_ready = 1'b1;
    check("t1_aw_ready", bus.aw_ready, 1'b1);
    check("t1_w_ready", bus.w_ready, 1'b1);
    @(negedge clk);
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    check("t1_b_early", bus.b_valid, 1'b0);
    check("t1_pulse_early", pulse, 8'h00);
    @(negedge clk);
    check("t1_b_valid", bus.b_valid, 1'b1);
    check("t1_b_resp", bus.b_resp, RESP_OKAY);
    check("t1_reg1", reg_at(1), 32'hDEADBEEF);
    check("t1_pulse", pulse, 8'b0000_0010);
    @(negedge clk);
    check("t1_b_done", bus.b_valid, 1'b0);
    check("t1_pulse_off", pulse, 8'h00);
    bus.b_ready = 1'b0;

    // 2: W three cycles ahead of AW.
    bus.w_data = 32'h000000AA; bus.w_strb = 4'h1; bus.w_valid = 1'b1;
    bus.b_ready = 1'b1;
    check("t2_w_ready", bus.w_ready, 1'b1);
    @(negedge clk);
    bus.w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_w_ready_held", bus.w_ready, 1'b0);
      check("t2_no_b", bus.b_valid, 1'b0);
      if (i < 2) @(negedge clk);
    end
    bus.aw_addr = 16'h0008; bus.aw_valid = 1'b1;
    @(negedge clk);
    bus.aw_valid = 1'b0;
    @(negedge clk);
    check("t2_b_valid", bus.b_valid, 1'b1);
    check("t2_b_resp", bus.b_resp, RESP_OKAY);
    bcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.b_valid) bcnt++;
    end
    check("t2_single_resp", bcnt, 0);
    check("t2_reg2", reg_at(2), 32'h000000AA);
    bus.b_ready = 1'b0;

    // 3: out-of-range write and read.
    snap = regs;
    p0 = pulse_cycles;
    do_write("t3w", 16'h0020, 32'hCAFEF00D, 4'hF, resp);
    check("t3_b_resp", resp, RESP_SLVERR);
    check("t3_regs_same", regs, snap);
    check("t3_no_pulse", pulse_cycles - p0, 0);
    do_read("t3r", 16'h0020, rdata, resp);
    check("t3_r_resp", resp, RESP_SLVERR);
    check("t3_r_data", rdata, 32'h0);

    // 4: partial strobe merge.
    do_write("t4a", 16'h000C, 32'h11223344, 4'hF, resp);
    check("t4a_resp", resp, RESP_OKAY);
    p0 = pulse_cycles;
    do_write("t4b", 16'h000C, 32'hAABBCCDD, 4'b0101, resp);
    check("t4b_resp", resp, RESP_OKAY);
    check("t4_reg3", reg_at(3), 32'h11BB33DD);
    check("t4_pulse_once", pulse_cycles - p0, 1);
    exp_q.push_back(32'h11BB33DD);
    do_read("t4r", 16'h000C, rdata, resp);
    check("t4_r_data", rdata, exp_q.pop_front());
    check("t4_r_resp", resp, RESP_OKAY);

    // 5: B held off for 10 cycles while a read runs and another write waits.
    send_aw_w(16'h0010, 32'h5555AAAA, 4'hF);
    bcnt = 0;
    while (!bus.b_valid && bcnt < 50) begin @(negedge clk); bcnt++; end
    check("t5_b_valid", bus.b_valid, 1'b1);
    check("t5_reg4", reg_at(4), 32'h5555AAAA);
    bus.aw_addr = 16'h0014; bus.aw_valid = 1'b1;
    bus.w_data = 32'h0F0F0F0F; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    bus.ar_addr = 16'h0004; bus.ar_valid = 1'b1; bus.r_ready = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    check("t5_ar_ready", bus.ar_ready, 1'b1);
    @(negedge clk);
    bus.ar_valid = 1'b0;
    check("t5_r_valid", bus.r_valid, 1'b1);
    check("t5_r_data", bus.r_data, exp_q.pop_front());
    check("t5_r_resp", bus.r_resp, RESP_OKAY);
    for (int i = 0; i < 9; i++) begin
      check("t5_b_hold", bus.b_valid, 1'b1);
      check("t5_b_resp_hold", bus.b_resp, RESP_OKAY);
      check("t5_aw_blocked", bus.aw_ready, 1'b0);
      check("t5_w_blocked", bus.w_ready, 1'b0);
      @(negedge clk);
    end
    bus.r_ready = 1'b0;
    bus.b_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0;
    check("t5_b_released", bus.b_valid, 1'b0);
    check("t5_aw_ready_after_b", bus.aw_ready, 1'b1);
    send_aw_w(16'h0014, 32'h0F0F0F0F, 4'hF);
    wait_b("t5w2", resp);
    check("t5_w2_resp", resp, RESP_OKAY);
    check("t5_reg5", reg_at(5), 32'h0F0F0F0F);

    // 6: reset during W_RESP and R_RESP.
    send_aw_w(16'h0000, 32'h00000077, 4'hF);
    bcnt = 0;
    while (!bus.b_valid && bcnt < 50) begin @(negedge clk); bcnt++; end
    bus.ar_addr = 16'h0000; bus.ar_valid = 1'b1;
    @(negedge clk);
    bus.ar_valid = 1'b0;
    check("t6_b_pending", bus.b_valid, 1'b1);
    check("t6_r_pending", bus.r_valid, 1'b1);
    check("t6_reg0_pre", reg_at(0), 32'h00000077);
    #2 rst = 1'b1;
    #1;
    check("t6_b_valid_rst", bus.b_valid, 1'b0);
    check("t6_r_valid_rst", bus.r_valid, 1'b0);
    check("t6_aw_ready_rst", bus.aw_ready, 1'b0);
    check("t6_w_ready_rst", bus.w_ready, 1'b0);
    check("t6_ar_ready_rst", bus.ar_ready, 1'b0);
    check("t6_regs_rst", regs, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_b_after", bus.b_valid, 1'b0);
    do_write("t6w", 16'h0000, 32'h12345678, 4'hF, resp);
    check("t6_w_resp", resp, RESP_OKAY);
    exp_q.push_back(32'h12345678);
    do_read("t6r", 16'h0000, rdata, resp);
    check("t6_r_resp", resp, RESP_OKAY);
    check("t6_r_data", rdata, exp_q.pop_front());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
